noise_burst_sequencer: RTL and testbench
========================================

# noise_burst_sequencer

Avalon-MM slave controller that drives the guitar-practice noise-enable line with a programmable on/off burst pattern instead of a static software-written bit. The Nios writes ON/OFF durations, a burst count and a mode, then issues START. The block sequences `noise_en` cycle-accurately, counts bursts and raises a level interrupt on completion. It sits on the same system interconnect as the other PIO-style slaves and replaces direct CPU toggling of the noise source.

## Interface
- `CNT_W`, 24: width of the ON/OFF duration registers and the phase timer (2..32).
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `address` in 3: register word index.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `readdata` out 32: combinational read mux of the addressed register; 0 for unmapped addresses.
- `noise_en` out 1: registered noise-enable output.
- `irq` out 1: registered level interrupt, equal to `done & IRQ_EN`.

## Operation
- A write occurs when `chipselect && !write_n`. Reads have no side effects.
- Register map (word index):
  - 0 CTRL:
    - bit0 START: write-1 pulse, reads 0.
    - bit1 STOP: write-1 pulse, reads 0.
    - bit2 CONT: 1 = continuous, 0 = finite.
    - bit3 IRQ_EN.
  - 1 ON_TIME [CNT_W-1:0], in cycles. Reset 0.
  - 2 OFF_TIME [CNT_W-1:0], in cycles. Reset 0.
  - 3 BURSTS [15:0]. Reset 0.
  - 4 STATUS:
    - bit0 busy.
    - bit1 done (sticky; write 1 to bit1 clears it).
    - bit2 `noise_en`.
    - [31:16] bursts remaining.
  - 5 TIMER: current phase timer value, read-only.
- FSM states are IDLE, ON and OFF. `noise_en` = 1 exactly while in state ON. busy = state != IDLE.
- Transitions:
  - IDLE → ON on START, provided ON_TIME != 0 and (CONT or BURSTS != 0).
    - The timer loads ON_TIME-1.
    - remaining loads BURSTS; in CONT mode remaining is forced to 0.
    - done is cleared.
    - Otherwise START is ignored: no state change and done is not touched.
  - ON, timer == 0, finite mode: remaining decrements.
    - If the new remaining is 0: go to IDLE and set done.
    - Else if OFF_TIME == 0: stay ON and reload ON_TIME-1.
    - Else: go to OFF and load OFF_TIME-1.
  - ON, timer == 0, CONT mode: same as finite, but remaining is never decremented and the block never ends on its own.
  - OFF, timer == 0: go to ON and load ON_TIME-1.
  - ON/OFF with timer != 0: timer decrements.
- Any state on STOP → IDLE. The timer and remaining are cleared and done is not set.
- START while busy restarts the sequence: same actions as IDLE → START, using current register values.
- STOP and START in the same write: STOP wins.
- ON_TIME and OFF_TIME writes while busy take effect at the next phase reload only. BURSTS writes while busy do not affect remaining.
- A done-clear write in the same cycle as completion: set wins.
- CONT changes while busy take effect at the next ON-phase end.
- Timer arithmetic is unsigned CNT_W bits with no wrap. The timer only reaches 0 through countdown.

## Timing
- Reset values:
  - State IDLE.
  - All registers 0.
  - `noise_en` = 0, `irq` = 0, `readdata` = 0.
  - done = 0, busy = 0.
- Reset mid-burst: `noise_en` drops the cycle after the reset edge, with no completion and no irq.
- A START write sampled at edge E0 gives `noise_en` = 1 from E0 to E0+ON_TIME.
  - High exactly ON_TIME cycles per burst, low exactly OFF_TIME cycles between bursts.
  - Period is ON_TIME+OFF_TIME.
- Completion: `noise_en` falls and done sets on the same edge. `irq` rises on the same edge when IRQ_EN = 1.
- STOP sampled at E0 gives `noise_en` = 0 after E0.
- Read path is combinational with zero wait states. STATUS and TIMER reflect post-edge register values.

## Test plan
- Finite burst:
  - Stimulus: ON_TIME=4, OFF_TIME=3, BURSTS=2, IRQ_EN=1, START.
  - Required: `noise_en` pattern 1111 000 1111 then 0.
  - done = 1 and `irq` = 1 on the edge of the final fall.
  - STATUS = 0x0000_0002 afterwards.
- Zero OFF_TIME merges bursts:
  - Stimulus: ON_TIME=3, OFF_TIME=0, BURSTS=3.
  - Required: `noise_en` high for 9 contiguous cycles; STATUS[31:16] reads 3, 2, 1, 0 at the burst boundaries.
- Continuous then STOP:
  - Stimulus: CONT=1, ON_TIME=2, OFF_TIME=2, START; STOP at cycle 7.
  - Required: pattern 1100 11 then 0.
  - done = 0, `irq` = 0, busy = 0.
- Illegal start:
  - Stimulus: START with ON_TIME=0; separately START with BURSTS=0, CONT=0.
  - Required: busy stays 0, `noise_en` stays 0, a prior done value is unchanged.
- Restart and simultaneous events:
  - Stimulus: START mid-burst; STOP+START in one write; done-clear write on the completion edge.
  - Required: the restart reloads ON_TIME and BURSTS and `noise_en` stays 1.
  - STOP+START ends in IDLE.
  - done reads 1 after the done-clear/completion collision.
- Reset mid-operation:
  - Stimulus: assert `reset` while in ON with remaining=5.
  - Required: next cycle all registers 0, `noise_en` = 0, `irq` = 0, `readdata` of every address = 0.

Source files
------------

// File: rtl/noise_burst_sequencer.sv
// noise_burst_sequencer: Avalon-MM slave that sequences noise_en as programmable ON/OFF bursts.
//   clk, reset                  : system clock, synchronous active-high reset
//   address, chipselect,
//   write_n, writedata          : Avalon-MM slave write port (word-indexed registers)
//   readdata                    : combinational read mux, 0 for unmapped addresses
//   noise_en                    : registered noise-enable, high exactly while in ON
//   irq                         : registered level interrupt, done & IRQ_EN
module noise_burst_sequencer #(
    parameter int CNT_W = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        noise_en,
    output logic        irq
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] on_time, off_time, timer, timer_n;
    logic [15:0]      bursts, remaining, rem_n;
    logic             cont, irq_en, done, done_n, cont_n, irq_en_n;
    logic             wr, ctrl_wr, start, stop, done_clr, legal, busy;

    assign wr       = chipselect && !write_n;
    assign ctrl_wr  = wr && address == 3'd0;
    assign start    = ctrl_wr && writedata[0];
    assign stop     = ctrl_wr && writedata[1];
    assign done_clr = wr && address == 3'd4 && writedata[1];
    // A START write that also sets CONT runs continuously from the first burst.
    assign cont_n   = ctrl_wr ? writedata[2] : cont;
    assign irq_en_n = ctrl_wr ? writedata[3] : irq_en;
    assign legal    = on_time != '0 && (cont_n || bursts != 16'd0);
    assign busy     = state != S_IDLE;

    always_comb begin
        state_n = state;
        timer_n = timer;
        rem_n   = remaining;
        done_n  = done;
        if (done_clr)
            done_n = 1'b0;
        if (stop) begin
            state_n = S_IDLE;
            timer_n = '0;
            rem_n   = '0;
        end else if (start && legal) begin
            state_n = S_ON;
            timer_n = on_time - CNT_W'(1);
            rem_n   = cont_n ? 16'd0 : bursts;
            done_n  = 1'b0;
        end else if (busy) begin
            if (timer != '0) begin
                timer_n = timer - CNT_W'(1);
            end else if (state == S_OFF) begin
                state_n = S_ON;
                timer_n = on_time - CNT_W'(1);
            end else if (!cont && remaining <= 16'd1) begin
                // Last burst ends; also catches CONT cleared mid-run with remaining 0.
                // Completion set takes priority over a same-cycle done clear.
                state_n = S_IDLE;
                rem_n   = '0;
                done_n  = 1'b1;
            end else begin
                rem_n = cont ? remaining : remaining - 16'd1;
                if (off_time == '0) begin
                    timer_n = on_time - CNT_W'(1);
                end else begin
                    state_n = S_OFF;
                    timer_n = off_time - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            timer     <= '0;
            remaining <= '0;
            done      <= 1'b0;
            cont      <= 1'b0;
            irq_en    <= 1'b0;
            on_time   <= '0;
            off_time  <= '0;
            bursts    <= '0;
            noise_en  <= 1'b0;
            irq       <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            remaining <= rem_n;
            done      <= done_n;
            cont      <= cont_n;
            irq_en    <= irq_en_n;
            noise_en  <= state_n == S_ON;
            irq       <= done_n && irq_en_n;
            if (wr && address == 3'd1)
                on_time <= writedata[CNT_W-1:0];
            if (wr && address == 3'd2)
                off_time <= writedata[CNT_W-1:0];
            if (wr && address == 3'd3)
                bursts <= writedata[15:0];
        end
    end

    always_comb begin
        case (address)
            3'd0:    readdata = {28'd0, irq_en, cont, 2'b00};
            3'd1:    readdata = 32'(on_time);
            3'd2:    readdata = 32'(off_time);
            3'd3:    readdata = {16'd0, bursts};
            3'd4:    readdata = {remaining, 13'd0, noise_en, done, busy};
            3'd5:    readdata = 32'(timer);
            default: readdata = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_noise_burst_sequencer.sv
// tb_noise_burst_sequencer: scoreboard bench for noise_burst_sequencer.
//   Drives the Avalon-MM write port, samples outputs on the falling edge.
module tb_noise_burst_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        noise_en;
    logic        irq;

    int passed = 0;
    int total = 0;
    int exp_noise[$];
    int exp_rem[$];

    noise_burst_sequencer #(.CNT_W(24)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .noise_en(noise_en), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    task automatic drive_wr(input logic [2:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
    endtask

    task automatic release_wr();
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        drive_wr(a, d);
        @(negedge clk);
        release_wr();
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        total++;
        if (noise_en !== 1'b0 || irq !== 1'b0)
            $display("FAIL reset_outputs: noise_en=%b irq=%b required 0 0", noise_en, irq);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), d);
            total++;
            if (d !== 32'd0) $display("FAIL reset_read[%0d]: got %h required 0", i, d);
            else passed++;
        end
    endtask

    task automatic test_finite_burst();
        logic [31:0] d;
        int e;
        wr(3'd1, 4);
        wr(3'd2, 3);
        wr(3'd3, 2);
        wr(3'd0, 32'h9);
        for (int i = 0; i < 12; i++) exp_noise.push_back((i < 4 || (i >= 7 && i < 11)) ? 1 : 0);
        for (int i = 0; i < 12; i++) begin
            e = exp_noise.pop_front();
            total++;
            if (noise_en !== 1'(e)) $display("FAIL finite_pattern[%0d]: got %b required %0d", i, noise_en, e);
            else passed++;
            if (i == 10 || i == 11) begin
                total++;
                if (irq !== (i == 11)) $display("FAIL finite_irq[%0d]: got %b required %b", i, irq, i == 11);
                else passed++;
            end
            if (i == 11) begin
                rd(3'd4, d);
                total++;
                if (d !== 32'h2) $display("FAIL finite_status: got %h required 00000002", d);
                else passed++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_zero_off();
        logic [31:0] d;
        int e;
        int r;
        wr(3'd1, 3);
        wr(3'd2, 0);
        wr(3'd3, 3);
        wr(3'd0, 32'h1);
        for (int i = 0; i < 10; i++) begin
            exp_noise.push_back(i < 9 ? 1 : 0);
            exp_rem.push_back(i < 3 ? 3 : i < 6 ? 2 : i < 9 ? 1 : 0);
        end
        for (int i = 0; i < 10; i++) begin
            e = exp_noise.pop_front();
            r = exp_rem.pop_front();
            total++;
            if (noise_en !== 1'(e)) $display("FAIL zero_off_pattern[%0d]: got %b required %0d", i, noise_en, e);
            else passed++;
            if (i % 3 == 0) begin
                rd(3'd4, d);
                total++;
                if (d[31:16] !== 16'(r)) $display("FAIL zero_off_remaining[%0d]: got %0d required %0d", i, d[31:16], r);
                else passed++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_cont_stop();
        logic [31:0] d;
        int e;
        wr(3'd1, 2);
        wr(3'd2, 2);
        wr(3'd0, 32'h5);
        for (int i = 0; i < 7; i++) exp_noise.push_back((i == 2 || i == 3 || i == 6) ? 0 : 1);
        for (int i = 0; i < 7; i++) begin
            e = exp_noise.pop_front();
            total++;
            if (noise_en !== 1'(e)) $display("FAIL cont_pattern[%0d]: got %b required %0d", i, noise_en, e);
            else passed++;
            if (i == 5) drive_wr(3'd0, 32'h2);
            @(negedge clk);
            if (i == 5) release_wr();
        end
        rd(3'd4, d);
        total++;
        if (d !== 32'd0 || irq !== 1'b0)
            $display("FAIL cont_stop_status: got status=%h irq=%b required 00000000 0", d, irq);
        else passed++;
    endtask

    task automatic test_illegal_start();
        logic [31:0] d;
        wr(3'd1, 1);
        wr(3'd2, 0);
        wr(3'd3, 1);
        wr(3'd0, 32'h1);
        repeat (2) @(negedge clk);
        rd(3'd4, d);
        total++;
        if (d !== 32'h2) $display("FAIL illegal_setup_done: got %h required 00000002", d);
        else passed++;
        wr(3'd1, 0);
        wr(3'd0, 32'h1);
        for (int i = 0; i < 3; i++) begin
            rd(3'd4, d);
            total++;
            if (d !== 32'h2 || noise_en !== 1'b0)
                $display("FAIL illegal_on_zero[%0d]: got status=%h noise_en=%b required 00000002 0", i, d, noise_en);
            else passed++;
            @(negedge clk);
        end
        wr(3'd1, 2);
        wr(3'd3, 0);
        wr(3'd0, 32'h1);
        for (int i = 0; i < 3; i++) begin
            rd(3'd4, d);
            total++;
            if (d !== 32'h2 || noise_en !== 1'b0)
                $display("FAIL illegal_bursts_zero[%0d]: got status=%h noise_en=%b required 00000002 0", i, d, noise_en);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_restart_collide();
        logic [31:0] d;
        wr(3'd1, 10);
        wr(3'd2, 2);
        wr(3'd3, 3);
        wr(3'd0, 32'h1);
        wr(3'd3, 2);
        rd(3'd4, d);
        total++;
        if (d[31:16] !== 16'd3 || noise_en !== 1'b1)
            $display("FAIL busy_bursts_write: got remaining=%0d noise_en=%b required 3 1", d[31:16], noise_en);
        else passed++;
        wr(3'd0, 32'h1);
        rd(3'd4, d);
        total++;
        if (d[31:16] !== 16'd2 || noise_en !== 1'b1)
            $display("FAIL restart_reload: got remaining=%0d noise_en=%b required 2 1", d[31:16], noise_en);
        else passed++;
        rd(3'd5, d);
        total++;
        if (d !== 32'd9) $display("FAIL restart_timer: got %0d required 9", d);
        else passed++;
        wr(3'd0, 32'h3);
        rd(3'd4, d);
        total++;
        if (d !== 32'd0 || noise_en !== 1'b0)
            $display("FAIL stop_start: got status=%h noise_en=%b required 00000000 0", d, noise_en);
        else passed++;
        wr(3'd1, 3);
        wr(3'd2, 0);
        wr(3'd3, 1);
        wr(3'd0, 32'h1);
        @(negedge clk);
        @(negedge clk);
        drive_wr(3'd4, 32'h2);
        @(negedge clk);
        release_wr();
        rd(3'd4, d);
        total++;
        if (d !== 32'h2) $display("FAIL clear_vs_set: got %h required 00000002", d);
        else passed++;
        wr(3'd4, 32'h2);
        rd(3'd4, d);
        total++;
        if (d !== 32'h0) $display("FAIL done_clear: got %h required 00000000", d);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        wr(3'd1, 20);
        wr(3'd2, 0);
        wr(3'd3, 5);
        wr(3'd0, 32'h9);
        @(negedge clk);
        rd(3'd4, d);
        total++;
        if (d[31:16] !== 16'd5 || noise_en !== 1'b1)
            $display("FAIL reset_mid_pre: got remaining=%0d noise_en=%b required 5 1", d[31:16], noise_en);
        else passed++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (noise_en !== 1'b0 || irq !== 1'b0)
            $display("FAIL reset_mid_outputs: noise_en=%b irq=%b required 0 0", noise_en, irq);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), d);
            total++;
            if (d !== 32'd0) $display("FAIL reset_mid_read[%0d]: got %h required 0", i, d);
            else passed++;
        end
        repeat (3) @(negedge clk);
        total++;
        if (noise_en !== 1'b0 || irq !== 1'b0)
            $display("FAIL reset_mid_after: noise_en=%b irq=%b required 0 0", noise_en, irq);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_finite_burst();
        test_zero_off();
        test_cont_stop();
        test_illegal_start();
        test_restart_collide();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
